// File: rtl/boot_loader_if.sv
// Loader-side bus bundle: byte stream in, memory write bus and status out.
// Stream handshake: a byte transfers on a rising clk edge when in_valid && in_ready; in_data is held while in_valid is high and ready low.
interface boot_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] mem_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic              cpu_reset_n;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, mem_data, mem_addr, mem_write, cpu_reset_n, busy, done, err
   );

   modport master (
      output start, in_data, in_valid,
      input  in_ready, mem_data, mem_addr, mem_write, cpu_reset_n, busy, done, err
   );
endinterface

// File: rtl/boot_loader.sv
// Streams LOAD_LEN bytes into memory at sequential addresses, holding the CPU in reset until done.
// Optional trailing checksum byte verification when CHECKSUM_EN is defined.
module boot_loader #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int LOAD_LEN   = 256,
   parameter int START_ADDR = 0
) (
   input  logic        clk,
   input  logic        reset,
   boot_loader_if.slave bus,
   output logic [2:0]  dbg_state_o
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2
`ifdef CHECKSUM_EN
      ,
      S_CHECK = 3'd3,
      S_ERR   = 3'd4
`endif
   } state_t;

   localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(LOAD_LEN - 1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [DATA_W-1:0]   mem_data_q, mem_data_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_write_q, mem_write_d;
   logic                cpu_rst_n_q, cpu_rst_n_d;
   logic                in_ready;
   logic                xfer;
   logic                restart;
`ifdef CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic [DATA_W-1:0]   ck_total;
   assign ck_total = sum_q + bus.in_data;
   assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
   assign in_ready = (state_q == S_LOAD);
`endif
   assign xfer = bus.in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      mem_data_d  = mem_data_q;
      mem_addr_d  = mem_addr_q;
      mem_write_d = 1'b0;
      cpu_rst_n_d = 1'b0;
      restart     = 1'b0;
`ifdef CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         S_IDLE: restart = bus.start;
         S_LOAD: begin
            if (xfer) begin
               mem_data_d  = bus.in_data;
               mem_addr_d  = addr_q;
               mem_write_d = 1'b1;
               addr_d      = addr_q + ADDR_ONE;
               count_d     = count_q + CNT_ONE;
`ifdef CHECKSUM_EN
               sum_d       = sum_q + bus.in_data;
               if (count_q == LAST_CNT) state_d = S_CHECK;
`else
               if (count_q == LAST_CNT) state_d = S_RUN;
`endif
            end
         end
`ifdef CHECKSUM_EN
         S_CHECK: begin
            if (xfer) state_d = (ck_total == '0) ? S_RUN : S_ERR;
         end
         S_ERR: restart = bus.start;
`endif
         S_RUN: begin
            // CPU leaves reset one cycle after entering RUN, after the last write strobe.
            cpu_rst_n_d = ~bus.start;
            restart     = bus.start;
         end
         default: state_d = S_IDLE;
      endcase
      if (restart) begin
         state_d = S_LOAD;
         addr_d  = START_A;
         count_d = '0;
`ifdef CHECKSUM_EN
         sum_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         addr_q      <= START_A;
         count_q     <= '0;
         mem_data_q  <= '0;
         mem_addr_q  <= START_A;
         mem_write_q <= 1'b0;
         cpu_rst_n_q <= 1'b0;
`ifdef CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         mem_data_q  <= mem_data_d;
         mem_addr_q  <= mem_addr_d;
         mem_write_q <= mem_write_d;
         cpu_rst_n_q <= cpu_rst_n_d;
`ifdef CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.mem_data    = mem_data_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_write   = mem_write_q;
   assign bus.cpu_reset_n = cpu_rst_n_q;
   assign bus.done        = (state_q == S_RUN);
`ifdef CHECKSUM_EN
   assign bus.busy        = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign bus.err         = (state_q == S_ERR);
`else
   assign bus.busy        = (state_q == S_LOAD);
   assign bus.err         = 1'b0;
`endif
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (START_ADDR 0 and 0xFE), LOAD_LEN 4.
module tb_boot_loader;
   logic clk = 1'b0;
   logic rst0_n, rst1_n;
   logic [2:0] dbg0, dbg1;
   int checks = 0;
   int errors = 0;

   logic [15:0] exp0_q[$];
   logic [15:0] exp1_q[$];

   boot_loader_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
   boot_loader_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

   boot_loader #(.ADDR_W(8), .DATA_W(8), .LOAD_LEN(4), .START_ADDR(0))
      dut0 (.clk(clk), .reset(rst0_n), .bus(if0), .dbg_state_o(dbg0));
   boot_loader #(.ADDR_W(8), .DATA_W(8), .LOAD_LEN(4), .START_ADDR(8'hFE))
      dut1 (.clk(clk), .reset(rst1_n), .bus(if1), .dbg_state_o(dbg1));

   always #5 clk = ~clk;

   // status = {in_ready, mem_write, cpu_reset_n, busy, done, err}
   logic [5:0] st0, st1;
   assign st0 = {if0.in_ready, if0.mem_write, if0.cpu_reset_n, if0.busy, if0.done, if0.err};
   assign st1 = {if1.in_ready, if1.mem_write, if1.cpu_reset_n, if1.busy, if1.done, if1.err};

`ifdef CHECKSUM_EN
   localparam logic LAST_WR = 1'b0;
`else
   localparam logic LAST_WR = 1'b1;
`endif

   // write scoreboards
   always @(negedge clk) begin
      if (if0.mem_write) begin
         checks++;
         if (exp0_q.size() == 0) begin
            errors++;
            $display("FAIL wr0_unexpected addr=%h data=%h", if0.mem_addr, if0.mem_data);
         end else begin
            logic [15:0] e;
            e = exp0_q.pop_front();
            if ({if0.mem_addr, if0.mem_data} !== e) begin
               errors++;
               $display("FAIL wr0 got=%h exp=%h", {if0.mem_addr, if0.mem_data}, e);
            end
         end
      end
      if (if1.mem_write) begin
         checks++;
         if (exp1_q.size() == 0) begin
            errors++;
            $display("FAIL wr1_unexpected addr=%h data=%h", if1.mem_addr, if1.mem_data);
         end else begin
            logic [15:0] e;
            e = exp1_q.pop_front();
            if ({if1.mem_addr, if1.mem_data} !== e) begin
               errors++;
               $display("FAIL wr1 got=%h exp=%h", {if1.mem_addr, if1.mem_data}, e);
            end
         end
      end
   end

   task automatic drive(input int sel, input logic st, input logic v, input logic [7:0] d);
      if (sel == 0) begin
         if0.start = st; if0.in_valid = v; if0.in_data = d;
      end else begin
         if1.start = st; if1.in_valid = v; if1.in_data = d;
      end
   endtask

   task automatic do_start(input int sel);
      drive(sel, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_status(input string name, input int sel, input logic [5:0] exp);
      logic [5:0] obs;
      obs = (sel == 0) ? st0 : st1;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s status got=%b exp=%b", name, obs, exp);
      end
   endtask

   // Sends n bytes (MSB first of bytes); start pulsed with byte start_idx.
   // A full stream (n==4) appends the checksum byte when the checksum build is active.
   task automatic send_stream(input int sel, input int gap, input logic [7:0] base,
                              input logic [31:0] bytes, input int n, input int start_idx);
      logic [7:0] b;
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         b = bytes[31-8*i -: 8];
         if (sel == 0) exp0_q.push_back({base + 8'(i), b});
         else          exp1_q.push_back({base + 8'(i), b});
         sum = sum + b;
         checks++;
         if (((sel == 0) ? if0.in_ready : if1.in_ready) !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_load sel=%0d byte=%0d got=0 exp=1", sel, i);
         end
         drive(sel, (i == start_idx), 1'b1, b);
         @(negedge clk);
         drive(sel, 1'b0, 1'b0, 8'h00);
         if (i < n - 1) repeat (gap) @(negedge clk);
      end
`ifdef CHECKSUM_EN
      if (n == 4) begin
         drive(sel, 1'b0, 1'b1, 8'h00 - sum);
         @(negedge clk);
         drive(sel, 1'b0, 1'b0, 8'h00);
      end
`endif
   endtask

   task automatic finish_load(input string name, input int sel);
      check_status({name, "_run"}, sel, {1'b0, LAST_WR, 1'b0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      check_status({name, "_cpu"}, sel, 6'b001010);
      checks++;
      if (((sel == 0) ? exp0_q.size() : exp1_q.size()) != 0) begin
         errors++;
         $display("FAIL %s_missing writes_left=%0d exp=0", name,
                  (sel == 0) ? exp0_q.size() : exp1_q.size());
      end
   endtask

   task automatic test_reset();
      rst0_n = 1'b0; rst1_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      check_status("reset0", 0, 6'b000000);
      check_status("reset1", 1, 6'b000000);
      checks++;
      if ({if0.mem_addr, if0.mem_data, if1.mem_addr, if1.mem_data} !== 32'h0000_FE00) begin
         errors++;
         $display("FAIL reset_bus got=%h exp=0000fe00",
                  {if0.mem_addr, if0.mem_data, if1.mem_addr, if1.mem_data});
      end
      rst0_n = 1'b1; rst1_n = 1'b1;
      repeat (2) @(negedge clk);
      check_status("idle0", 0, 6'b000000);
   endtask

   task automatic test_back_to_back();
      do_start(0);
      check_status("b2b_load", 0, 6'b100100);
      send_stream(0, 0, 8'h00, 32'h11223344, 4, -1);
      finish_load("b2b", 0);
   endtask

   task automatic test_gaps();
      do_start(0);
      send_stream(0, 3, 8'h00, 32'h11223344, 4, -1);
      finish_load("gaps", 0);
   endtask

   task automatic test_wrap();
      do_start(1);
      send_stream(1, 0, 8'hFE, 32'hA0B1C2D3, 4, -1);
      finish_load("wrap", 1);
   endtask

   task automatic test_reset_mid_load();
      do_start(0);
      send_stream(0, 0, 8'h00, 32'h55660000, 2, -1);
      drive(0, 1'b0, 1'b1, 8'h77);
      #2 rst0_n = 1'b0;
      #1;
      check_status("midrst", 0, 6'b000000);
      checks++;
      if ({if0.mem_addr, if0.mem_data, dbg0} !== 19'h0) begin
         errors++;
         $display("FAIL midrst_bus got=%h exp=0", {if0.mem_addr, if0.mem_data, dbg0});
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst0_n = 1'b1;
      @(negedge clk);
      do_start(0);
      send_stream(0, 1, 8'h00, 32'h9A8B7C6D, 4, -1);
      finish_load("reload", 0);
   endtask

   task automatic test_start_ignored();
      do_start(0);
      send_stream(0, 0, 8'h00, 32'h01102030, 4, 2);
      finish_load("ign", 0);
      do_start(0);
      check_status("restart", 0, 6'b100100);
      send_stream(0, 0, 8'h00, 32'hDEADBEEF, 4, -1);
      finish_load("restart", 0);
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      logic [39:0] bad;
      do_start(0);
      send_stream(0, 0, 8'h00, 32'h01020304, 4, -1);
      finish_load("ck_good", 0);
      bad = 40'h01020304F7;
      do_start(0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp0_q.push_back({8'(i), bad[39-8*i -: 8]});
         drive(0, 1'b0, 1'b1, bad[39-8*i -: 8]);
         @(negedge clk);
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      check_status("ck_bad", 0, 6'b000001);
      repeat (3) @(negedge clk);
      check_status("ck_bad_hold", 0, 6'b000001);
      do_start(0);
      check_status("ck_restart", 0, 6'b100100);
      send_stream(0, 0, 8'h00, 32'h01020304, 4, -1);
      finish_load("ck_recover", 0);
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_wrap();
      test_reset_mid_load();
      test_start_ignored();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
